// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the instruction memory.
//
// Receives a byte stream over a valid/ready handshake, assembles little-endian
// 32-bit words and writes them to consecutive word addresses starting at 0.
// The core is held in reset until the complete image has been stored.
//
// Stream: 2-byte word count N (low byte first), then N*4 payload bytes, and,
// when IMEM_LOADER_CKSUM_EN is defined, one trailing byte holding the XOR of
// all payload bytes.
//
// Optional feature macro: IMEM_LOADER_CKSUM_EN (trailing checksum byte).
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous reset, active low
//   in_valid  stream byte valid
//   in_data   stream byte
//   in_ready  loader can accept a byte (decoded from state)
//   reload    single-cycle restart request, honoured in DONE or ERR only
//   im_we     instruction-memory write strobe, one cycle per word
//   im_addr   instruction-memory word address
//   im_wdata  instruction-memory write data
//   cpu_rst   active-high core reset, released once the load completes
//   done      image loaded and core released
//   err       load rejected, core stays in reset
module imem_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        StHdr0,
        StHdr1,
        StData,
`ifdef IMEM_LOADER_CKSUM_EN
        StCksum,
`endif
        StFlush,
        StDone,
        StErr
    } state_e;

    // State entered once the payload (possibly empty) has been consumed.
`ifdef IMEM_LOADER_CKSUM_EN
    localparam state_e StAfterPayload = StCksum;
`else
    localparam state_e StAfterPayload = StFlush;
`endif

    // Capacity in words; 17 bits so it can be compared with any 16-bit count.
    localparam logic [16:0] MaxWords = 17'(1) << ADDR_W;

    state_e          state;
    logic [15:0]     count;
    // One bit wider than the address so a full-capacity image does not wrap.
    logic [ADDR_W:0] word_idx;
    logic [1:0]      byte_cnt;
    logic [23:0]     asm_word;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]      cksum;
`endif

    logic            accept;
    logic [16:0]     hdr_count;
    logic [ADDR_W:0] word_idx_nxt;
    logic            last_word;

    assign accept       = in_valid && in_ready;
    assign hdr_count    = {1'b0, in_data, count[7:0]};
    assign word_idx_nxt = word_idx + (ADDR_W + 1)'(1);
    assign last_word    = (17'(word_idx_nxt) == {1'b0, count});

    always_comb begin
        in_ready = 1'b0;
        case (state)
            StHdr0, StHdr1, StData: in_ready = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
            StCksum:                in_ready = 1'b1;
`endif
            default:                in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= StHdr0;
            count    <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            asm_word <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum    <= '0;
`endif
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse.
            im_we <= 1'b0;
            case (state)
                StHdr0: begin
                    if (accept) begin
                        count[7:0] <= in_data;
                        state      <= StHdr1;
                    end
                end
                StHdr1: begin
                    if (accept) begin
                        count[15:8] <= in_data;
                        if (hdr_count > MaxWords) begin
                            state <= StErr;
                            err   <= 1'b1;
                        end else if (hdr_count == 17'd0) begin
                            state <= StAfterPayload;
                        end else begin
                            state <= StData;
                        end
                    end
                end
                StData: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CKSUM_EN
                        cksum <= cksum ^ in_data;
`endif
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: asm_word[7:0]   <= in_data;
                            2'd1: asm_word[15:8]  <= in_data;
                            2'd2: asm_word[23:16] <= in_data;
                            default: begin
                                im_wdata <= {in_data, asm_word};
                                im_addr  <= word_idx[ADDR_W-1:0];
                                im_we    <= 1'b1;
                                word_idx <= word_idx_nxt;
                                if (last_word) begin
                                    state <= StAfterPayload;
                                end
                            end
                        endcase
                    end
                end
`ifdef IMEM_LOADER_CKSUM_EN
                StCksum: begin
                    if (accept) begin
                        if (in_data == cksum) begin
                            state <= StFlush;
                        end else begin
                            state <= StErr;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                StFlush: begin
                    // Lets the final write strobe finish before the core is released.
                    state   <= StDone;
                    cpu_rst <= 1'b0;
                    done    <= 1'b1;
                end
                StDone, StErr: begin
                    if (reload) begin
                        state    <= StHdr0;
                        cpu_rst  <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        word_idx <= '0;
                        byte_cnt <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
                        cksum    <= '0;
`endif
                    end
                end
                default: state <= StHdr0;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. A behavioural model derives the
// expected write list and final status from the stream contents; a monitor
// records every memory write the loader performs.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 10;
    localparam int          DEPTH  = 1 << ADDR_W;
`ifdef IMEM_LOADER_CKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              reload = 1'b0;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .reload   (reload),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0]       words_q[$];
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       exp_data_q[$];
    bit                exp_err;
    bit                hold_reload = 1'b0;

    // Memory-side view: a write lands on the edge that ends the strobe cycle.
    always @(posedge clk) begin
        if (im_we) begin
            wr_addr_q.push_back(im_addr);
            wr_data_q.push_back(im_wdata);
        end
    end

    // Release of the core must never coincide with a write strobe.
    always @(negedge clk) begin
        if (rst) begin
            tests++;
            if (im_we && done) begin
                fails++;
                $display("FAIL we_done_overlap got im_we=1 done=1 want not both");
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout want $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = b;
        reload   = hold_reload;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout got in_ready=0 want 1");
            in_valid = 1'b0;
            reload   = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        reload   = 1'b0;
    endtask

    task automatic gap(input int gmin, input int gmax);
        int g = $urandom_range(gmax, gmin);
        repeat (g) tick();
    endtask

    // Header, payload from words_q, then optional checksum (corrupted if ck_bad).
    task automatic send_stream(input int n, input int gmin, input int gmax, input bit ck_bad);
        logic [7:0] ck = 8'h00;
        logic [7:0] b;
        logic [15:0] n16 = 16'(n);
        gap(gmin, gmax); send_byte(n16[7:0]);
        gap(gmin, gmax); send_byte(n16[15:8]);
        if (n > DEPTH) return;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                b  = words_q[i][8*j +: 8];
                ck = ck ^ b;
                gap(gmin, gmax);
                send_byte(b);
            end
        end
        if (CK_EN) begin
            gap(gmin, gmax);
            send_byte(ck ^ {7'd0, ck_bad});
        end
    endtask

    // Reference model: what the memory should receive and whether the load fails.
    task automatic model_expect(input int n, input bit ck_bad);
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_err = (n > DEPTH) || (CK_EN && ck_bad);
        if (n <= DEPTH) begin
            for (int i = 0; i < n; i++) begin
                exp_addr_q.push_back(ADDR_W'(i));
                exp_data_q.push_back(words_q[i]);
            end
        end
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int c = 0;
        while (!(done || err) && c < 100) begin
            tick();
            c++;
        end
        tests++;
        if (!(done || err)) begin
            fails++;
            $display("FAIL %s end_timeout got done=0 err=0 want done|err=1", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        tests++;
        if ({in_ready, im_we, im_addr, im_wdata, cpu_rst, done, err} !==
            {1'b1, 1'b0, {ADDR_W{1'b0}}, 32'd0, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_in got rdy=%b we=%b a=%h d=%h crst=%b done=%b err=%b want 1 0 0 0 1 0 0",
                     in_ready, im_we, im_addr, im_wdata, cpu_rst, done, err);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) tick();
        tests++;
        if ({in_ready, im_we, cpu_rst, done, err} !== 5'b10100) begin
            fails++;
            $display("FAIL reset_idle got rdy=%b we=%b crst=%b done=%b err=%b want 1 0 1 0 0",
                     in_ready, im_we, cpu_rst, done, err);
        end
    endtask

    task automatic test_basic();
        words_q = '{32'h12345678, 32'h2008000C};
        model_expect(2, 1'b0);
        clear_writes();
        send_stream(2, 0, 0, 1'b0);
`ifndef IMEM_LOADER_CKSUM_EN
        tests++;
        if (im_we !== 1'b1 || im_addr !== ADDR_W'(1) || im_wdata !== 32'h2008000C) begin
            fails++;
            $display("FAIL basic_last_write got we=%b a=%0d d=%h want 1 1 2008000c",
                     im_we, im_addr, im_wdata);
        end
`endif
        tests++;
        if (done !== 1'b0 || cpu_rst !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_flush got done=%b crst=%b rdy=%b want 0 1 0", done, cpu_rst, in_ready);
        end
        tick();
        tests++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || err !== 1'b0 || im_we !== 1'b0) begin
            fails++;
            $display("FAIL basic_done got done=%b crst=%b err=%b we=%b want 1 0 0 0",
                     done, cpu_rst, err, im_we);
        end
        // A byte offered after completion must be ignored.
        in_valid = 1'b1;
        in_data  = 8'hAB;
        repeat (3) tick();
        in_valid = 1'b0;
        tests++;
        if (in_ready !== 1'b0 || done !== 1'b1) begin
            fails++;
            $display("FAIL basic_extra_byte got rdy=%b done=%b want 0 1", in_ready, done);
        end
        tests++;
        if (wr_addr_q.size() != exp_addr_q.size()) begin
            fails++;
            $display("FAIL basic_nwrites got %0d want %0d", wr_addr_q.size(), exp_addr_q.size());
        end else begin
            foreach (exp_addr_q[i]) begin
                tests++;
                if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
                    fails++;
                    $display("FAIL basic_write%0d got %0d:%h want %0d:%h", i,
                             wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        pulse_reload();
        words_q = '{32'h12345678, 32'h2008000C};
        model_expect(2, 1'b0);
        clear_writes();
        send_stream(2, 3, 3, 1'b0);
        wait_end("stall");
        tick();
        tests++;
        if (done !== 1'b1 || err !== 1'b0) begin
            fails++;
            $display("FAIL stall_status got done=%b err=%b want 1 0", done, err);
        end
        tests++;
        if (wr_addr_q.size() != exp_addr_q.size()) begin
            fails++;
            $display("FAIL stall_nwrites got %0d want %0d", wr_addr_q.size(), exp_addr_q.size());
        end else begin
            foreach (exp_addr_q[i]) begin
                tests++;
                if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
                    fails++;
                    $display("FAIL stall_write%0d got %0d:%h want %0d:%h", i,
                             wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
                end
            end
        end
    endtask

    task automatic test_zero();
        pulse_reload();
        words_q.delete();
        clear_writes();
        send_stream(0, 0, 0, 1'b0);
        tests++;
        if (done !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL zero_flush got done=%b rdy=%b want 0 0", done, in_ready);
        end
        tick();
        tests++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || wr_addr_q.size() != 0) begin
            fails++;
            $display("FAIL zero_done got done=%b crst=%b nwr=%0d want 1 0 0",
                     done, cpu_rst, wr_addr_q.size());
        end
    endtask

    task automatic test_oversize();
        pulse_reload();
        clear_writes();
        send_stream(DEPTH + 1, 0, 0, 1'b0);
        tests++;
        if (err !== 1'b1 || in_ready !== 1'b0 || cpu_rst !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL oversize got err=%b rdy=%b crst=%b done=%b want 1 0 1 0",
                     err, in_ready, cpu_rst, done);
        end
        repeat (3) tick();
        tests++;
        if (err !== 1'b1 || cpu_rst !== 1'b1 || wr_addr_q.size() != 0) begin
            fails++;
            $display("FAIL oversize_hold got err=%b crst=%b nwr=%0d want 1 1 0",
                     err, cpu_rst, wr_addr_q.size());
        end
    endtask

    task automatic test_reload();
        pulse_reload();
        tests++;
        if (cpu_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reload_clear got crst=%b done=%b err=%b rdy=%b want 1 0 0 1",
                     cpu_rst, done, err, in_ready);
        end
        words_q = '{32'hDEADBEEF, 32'h00000001, 32'hCAFEF00D};
        model_expect(3, 1'b0);
        clear_writes();
        send_stream(3, 0, 1, 1'b0);
        wait_end("reload");
        tick();
        tests++;
        if (wr_addr_q.size() != exp_addr_q.size() || done !== 1'b1) begin
            fails++;
            $display("FAIL reload_nwrites got %0d done=%b want %0d 1",
                     wr_addr_q.size(), done, exp_addr_q.size());
        end else begin
            foreach (exp_addr_q[i]) begin
                tests++;
                if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
                    fails++;
                    $display("FAIL reload_write%0d got %0d:%h want %0d:%h", i,
                             wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
                end
            end
        end
    endtask

    task automatic test_full_depth();
        int bad = 0;
        pulse_reload();
        words_q.delete();
        for (int i = 0; i < DEPTH; i++) words_q.push_back($urandom());
        model_expect(DEPTH, 1'b0);
        clear_writes();
        send_stream(DEPTH, 0, 0, 1'b0);
        wait_end("full");
        tick();
        tests++;
        if (done !== 1'b1 || err !== 1'b0 || wr_addr_q.size() != exp_addr_q.size()) begin
            fails++;
            $display("FAIL full_status got done=%b err=%b nwr=%0d want 1 0 %0d",
                     done, err, wr_addr_q.size(), exp_addr_q.size());
        end else begin
            foreach (exp_addr_q[i]) begin
                if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) bad++;
            end
            tests++;
            if (bad != 0) begin
                fails++;
                $display("FAIL full_writes got %0d wrong words want 0", bad);
            end
        end
    endtask

`ifdef IMEM_LOADER_CKSUM_EN
    task automatic test_checksum();
        for (int k = 0; k < 2; k++) begin
            pulse_reload();
            words_q = '{32'h44332211};
            clear_writes();
            send_byte(8'h01); send_byte(8'h00);
            send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
            send_byte((k == 0) ? 8'h44 : 8'h45);
            tick();
            tests++;
            if (done !== (k == 0) || err !== (k == 1) || cpu_rst !== (k == 1)) begin
                fails++;
                $display("FAIL cksum%0d got done=%b err=%b crst=%b want %0d %0d %0d",
                         k, done, err, cpu_rst, k == 0, k == 1, k == 1);
            end
            tests++;
            if (wr_addr_q.size() != 1 || wr_data_q[0] !== 32'h44332211 ||
                wr_addr_q[0] !== '0) begin
                fails++;
                $display("FAIL cksum%0d_write got nwr=%0d want 1 word 44332211 at 0",
                         k, wr_addr_q.size());
            end
        end
    endtask
`endif

    task automatic test_rst_abort();
        pulse_reload();
        words_q = '{32'hA5A55A5A, 32'h0F0F0F0F};
        clear_writes();
        send_byte(8'h02); send_byte(8'h00);
        for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i));
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if ({in_ready, im_we, im_addr, im_wdata, cpu_rst, done, err} !==
            {1'b1, 1'b0, {ADDR_W{1'b0}}, 32'd0, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL abort_reset got rdy=%b we=%b a=%h d=%h crst=%b done=%b err=%b want 1 0 0 0 1 0 0",
                     in_ready, im_we, im_addr, im_wdata, cpu_rst, done, err);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        model_expect(2, 1'b0);
        clear_writes();
        send_stream(2, 0, 1, 1'b0);
        wait_end("abort");
        tick();
        tests++;
        if (wr_addr_q.size() != exp_addr_q.size() || done !== 1'b1) begin
            fails++;
            $display("FAIL abort_nwrites got %0d done=%b want %0d 1",
                     wr_addr_q.size(), done, exp_addr_q.size());
        end else begin
            foreach (exp_addr_q[i]) begin
                tests++;
                if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
                    fails++;
                    $display("FAIL abort_write%0d got %0d:%h want %0d:%h", i,
                             wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
                end
            end
        end
    endtask

    // Random images, gaps and ignored reload pulses during the load.
    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int n = $urandom_range(12, 1);
            bit ck_bad = CK_EN && ($urandom_range(3, 0) == 0);
            pulse_reload();
            words_q.delete();
            for (int i = 0; i < n; i++) words_q.push_back($urandom());
            model_expect(n, ck_bad);
            clear_writes();
            hold_reload = ($urandom_range(1, 0) == 1);
            send_stream(n, 0, 2, ck_bad);
            hold_reload = 1'b0;
            wait_end("random");
            tick();
            tests++;
            if (err !== exp_err || done !== !exp_err || cpu_rst !== exp_err) begin
                fails++;
                $display("FAIL random%0d_status got err=%b done=%b crst=%b want err=%b",
                         it, err, done, cpu_rst, exp_err);
            end
            tests++;
            if (wr_addr_q.size() != exp_addr_q.size()) begin
                fails++;
                $display("FAIL random%0d_nwrites got %0d want %0d", it,
                         wr_addr_q.size(), exp_addr_q.size());
            end else begin
                foreach (exp_addr_q[i]) begin
                    tests++;
                    if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
                        fails++;
                        $display("FAIL random%0d_write%0d got %0d:%h want %0d:%h", it, i,
                                 wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_oversize();
        test_reload();
        test_full_depth();
`ifdef IMEM_LOADER_CKSUM_EN
        test_checksum();
`endif
        test_rst_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
